// File: rtl/dmem_region_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_region_bridge_if
// Description : CPU data-port and slave-side signal bundle for dmem_region_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_region_bridge_if #(
    parameter int NUM_REGIONS = 4
);
    logic                     cpu_req;
    logic                     cpu_we;
    logic [1:0]               cpu_width;
    logic                     cpu_sign;
    logic [31:0]              cpu_addr;
    logic [31:0]              cpu_wdata;
    logic [31:0]              cpu_rdata;
    logic                     cpu_ready;
    logic                     cpu_err;

    logic [NUM_REGIONS-1:0]    sl_sel;
    logic [31:0]               sl_addr;
    logic                      sl_we;
    logic [1:0]                sl_width;
    logic                      sl_sign;
    logic [31:0]               sl_wdata;
    logic [32*NUM_REGIONS-1:0] sl_rdata;
    logic [NUM_REGIONS-1:0]    sl_ack;

    // Environment view: the CPU issuing requests plus the slaves answering them
    modport master (
        output cpu_req, cpu_we, cpu_width, cpu_sign, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_err,
        input  sl_sel, sl_addr, sl_we, sl_width, sl_sign, sl_wdata,
        output sl_rdata, sl_ack
    );

    // Bridge view
    modport slave (
        input  cpu_req, cpu_we, cpu_width, cpu_sign, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_err,
        output sl_sel, sl_addr, sl_we, sl_width, sl_sign, sl_wdata,
        input  sl_rdata, sl_ack
    );
endinterface
`default_nettype wire

// File: rtl/dmem_region_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dmem_region_bridge
// Description : Data-side bridge decoding CPU accesses onto NUM_REGIONS slaves
//               with address rebasing, wait states, ack timeout and bus errors.
//               Optional macro MISALIGN_CHECK_EN turns misaligned accesses into
//               error completions instead of aligning the slave address.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_region_bridge #(
    parameter int                        NUM_REGIONS = 4,
    // Region 0 in the LSBs; a region whose mask is zero is an unused slot
    parameter logic [32*NUM_REGIONS-1:0] REGION_BASE = {32'h0000_0000, 32'hFFFF_0000,
                                                        32'h1002_0000, 32'h1001_0000},
    parameter logic [32*NUM_REGIONS-1:0] REGION_MASK = {32'h0000_0000, 32'hFFFF_FF00,
                                                        32'hFFFF_0000, 32'hFFFF_0000},
    parameter logic [4*NUM_REGIONS-1:0]  REGION_WAIT = {4'd0, 4'd2, 4'd1, 4'd0},
    parameter int                        TIMEOUT     = 255
) (
    input  wire                     clk_in,
    input  wire                     reset,
    dmem_region_bridge_if.slave     bus
);
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WAIT    = 2'd1;
    localparam logic [1:0] c_ACCESS  = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;
    localparam logic [7:0] c_TIMEOUT = TIMEOUT[7:0];

    logic [1:0]             r_state;
    logic [1:0]             w_next;
    logic [3:0]             r_wait_cnt;
    logic [7:0]             r_tmo_cnt;
    logic [NUM_REGIONS-1:0] r_target;
    logic [NUM_REGIONS-1:0] r_sel;
    logic                   r_err_pend;
    logic                   r_cpu_ready;
    logic                   r_cpu_err;
    logic [31:0]            r_cpu_rdata;
    logic [31:0]            r_sl_addr;
    logic                   r_sl_we;
    logic [1:0]             r_sl_width;
    logic                   r_sl_sign;
    logic [31:0]            r_sl_wdata;

    logic [NUM_REGIONS-1:0] w_hit;
    logic [NUM_REGIONS-1:0] w_hit_oh;
    logic                   w_hit_any;
    logic [31:0]            w_base;
    logic [3:0]             w_wait;
    logic [31:0]            w_offset_raw;
    logic [31:0]            w_offset;
    logic                   w_dec_err;
    logic                   w_ack;
    logic                   w_tmo;
    logic [31:0]            w_rdata;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_decode
        localparam logic [31:0] c_BASE = REGION_BASE[32*g +: 32];
        localparam logic [31:0] c_MASK = REGION_MASK[32*g +: 32];
        assign w_hit[g] = (c_MASK != 32'd0) && ((bus.cpu_addr & c_MASK) == c_BASE);
    end

    // Descending scan so the lowest-index hit is the one that sticks
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_oh  = '0;
        w_base    = 32'd0;
        w_wait    = 4'd0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hit_any   = 1'b1;
                w_hit_oh    = '0;
                w_hit_oh[i] = 1'b1;
                w_base      = REGION_BASE[32*i +: 32];
                w_wait      = REGION_WAIT[4*i +: 4];
            end
        end
    end

    assign w_offset_raw = bus.cpu_addr - w_base;

`ifdef MISALIGN_CHECK_EN
    logic w_misalign;
    always_comb begin
        w_misalign = 1'b0;
        if (bus.cpu_width == 2'd1)
            w_misalign = bus.cpu_addr[0];
        else if (bus.cpu_width == 2'd2)
            w_misalign = |bus.cpu_addr[1:0];
    end
    assign w_offset  = w_offset_raw;
    assign w_dec_err = !w_hit_any || w_misalign;
`else
    always_comb begin
        w_offset = w_offset_raw;
        if (bus.cpu_width == 2'd1)
            w_offset[0] = 1'b0;
        else if (bus.cpu_width == 2'd2)
            w_offset[1:0] = 2'b00;
    end
    assign w_dec_err = !w_hit_any;
`endif

    assign w_ack = |(bus.sl_ack & r_sel);
    assign w_tmo = (r_tmo_cnt + 8'd1) == c_TIMEOUT;

    always_comb begin
        w_rdata = 32'd0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (r_sel[i])
                w_rdata = bus.sl_rdata[32*i +: 32];
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)
            r_state <= c_IDLE;
        else
            r_state <= w_next;
    end

    // Decode errors pass through ACCESS with no slave selected and leave at
    // once, so they complete with the same two-cycle latency as a fast ack.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.cpu_req) begin
                    if (!w_dec_err && (w_wait != 4'd0))
                        w_next = c_WAIT;
                    else
                        w_next = c_ACCESS;
                end
            end
            c_WAIT: begin
                if (r_wait_cnt == 4'd1)
                    w_next = c_ACCESS;
            end
            c_ACCESS: begin
                if (r_err_pend || w_ack || w_tmo)
                    w_next = c_RESP;
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_wait_cnt  <= 4'd0;
            r_tmo_cnt   <= 8'd0;
            r_target    <= '0;
            r_sel       <= '0;
            r_err_pend  <= 1'b0;
            r_cpu_ready <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= 32'd0;
            r_sl_addr   <= 32'd0;
            r_sl_we     <= 1'b0;
            r_sl_width  <= 2'd0;
            r_sl_sign   <= 1'b0;
            r_sl_wdata  <= 32'd0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_cpu_rdata <= 32'd0;
            case (r_state)
                c_IDLE: begin
                    if (bus.cpu_req) begin
                        r_sl_addr  <= w_offset;
                        r_sl_we    <= bus.cpu_we;
                        r_sl_width <= bus.cpu_width;
                        r_sl_sign  <= bus.cpu_sign;
                        r_sl_wdata <= bus.cpu_wdata;
                        r_err_pend <= w_dec_err;
                        r_tmo_cnt  <= 8'd0;
                        r_target   <= w_dec_err ? '0 : w_hit_oh;
                        r_wait_cnt <= w_dec_err ? 4'd0 : w_wait;
                        if (!w_dec_err && (w_wait == 4'd0))
                            r_sel <= w_hit_oh;
                    end
                end
                c_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (r_wait_cnt == 4'd1)
                        r_sel <= r_target;
                end
                c_ACCESS: begin
                    r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    if (w_next == c_RESP) begin
                        r_sel       <= '0;
                        r_cpu_ready <= 1'b1;
                        r_cpu_err   <= !w_ack;
                        r_cpu_rdata <= (w_ack && !r_sl_we) ? w_rdata : 32'd0;
                    end
                end
                default: begin
                    r_wait_cnt <= 4'd0;
                    r_tmo_cnt  <= 8'd0;
                    r_err_pend <= 1'b0;
                    r_target   <= '0;
                end
            endcase
        end
    end

    assign bus.cpu_ready = r_cpu_ready;
    assign bus.cpu_err   = r_cpu_err;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.sl_sel    = r_sel;
    assign bus.sl_addr   = r_sl_addr;
    assign bus.sl_we     = r_sl_we;
    assign bus.sl_width  = r_sl_width;
    assign bus.sl_sign   = r_sl_sign;
    assign bus.sl_wdata  = r_sl_wdata;
endmodule
`default_nettype wire

// File: tb/tb_dmem_region_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_region_bridge
// Description : Directed self-checking bench for dmem_region_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_region_bridge;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_ticks;
    logic saw_ready;

    dmem_region_bridge_if #(.NUM_REGIONS(4)) bus ();

    dmem_region_bridge #(.NUM_REGIONS(4)) dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int max_ticks, inout int n);
        while (bus.cpu_ready !== 1'b1 && n < max_ticks) begin
            tick();
            n++;
        end
    endtask

    task automatic request(input logic we, input logic [1:0] width, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_width = width;
        bus.cpu_sign  = 1'b0;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic idle_bus();
        bus.cpu_req = 1'b0;
        bus.sl_ack  = 4'b0000;
    endtask

    initial begin
        idle_bus();
        bus.cpu_we    = 1'b0;
        bus.cpu_width = 2'd0;
        bus.cpu_sign  = 1'b0;
        bus.cpu_addr  = 32'd0;
        bus.cpu_wdata = 32'd0;
        bus.sl_rdata  = {32'h4444_4444, 32'h3333_3333, 32'h1234_5678, 32'hDEAD_BEEF};

        // Reset state
        #2 reset = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, bus.cpu_ready}, 32'd0);
        check("rst_err",   {31'd0, bus.cpu_err},   32'd0);
        check("rst_rdata", bus.cpu_rdata,          32'd0);
        check("rst_sel",   {28'd0, bus.sl_sel},    32'd0);
        check("rst_addr",  bus.sl_addr,            32'd0);
        reset = 1'b1;
        tick();

        // 1: word read region0, ack in first ACCESS cycle
        request(1'b0, 2'd2, 32'h1001_0008, 32'd0);
        bus.sl_ack = 4'b0001;
        tick();
        check("t1_sel",   {28'd0, bus.sl_sel},    32'h1);
        check("t1_addr",  bus.sl_addr,            32'h8);
        check("t1_early", {31'd0, bus.cpu_ready}, 32'd0);
        tick();
        check("t1_ready", {31'd0, bus.cpu_ready}, 32'd1);
        check("t1_err",   {31'd0, bus.cpu_err},   32'd0);
        check("t1_rdata", bus.cpu_rdata,          32'hDEAD_BEEF);
        idle_bus();
        tick();
        check("t1_pulse", {31'd0, bus.cpu_ready}, 32'd0);

        // 2: byte write region1 (1 wait), noise ack on slave0, real ack after 2 cycles
        request(1'b1, 2'd0, 32'h1002_0003, 32'h0000_00A5);
        bus.sl_ack = 4'b0001;
        tick();
        check("t2_wait_sel", {28'd0, bus.sl_sel},   32'h0);
        check("t2_addr",     bus.sl_addr,           32'h3);
        check("t2_width",    {30'd0, bus.sl_width}, 32'd0);
        check("t2_we",       {31'd0, bus.sl_we},    32'd1);
        check("t2_wdata",    bus.sl_wdata,          32'hA5);
        tick();
        check("t2_sel", {28'd0, bus.sl_sel}, 32'h2);
        tick();
        check("t2_noise", {31'd0, bus.cpu_ready}, 32'd0);
        tick();
        check("t2_early", {31'd0, bus.cpu_ready}, 32'd0);
        bus.sl_ack = 4'b0010;
        tick();
        check("t2_ready", {31'd0, bus.cpu_ready}, 32'd1);
        check("t2_err",   {31'd0, bus.cpu_err},   32'd0);
        check("t2_rdata", bus.cpu_rdata,          32'd0);
        idle_bus();
        tick();

        // Region1 read picks slave1 read data, latency 3
        request(1'b0, 2'd2, 32'h1002_0010, 32'd0);
        bus.sl_ack = 4'b0010;
        n_ticks = 0;
        wait_ready(20, n_ticks);
        check("r1_lat",   n_ticks,       32'd3);
        check("r1_rdata", bus.cpu_rdata, 32'h1234_5678);
        check("r1_addr",  bus.sl_addr,   32'h10);
        idle_bus();
        tick();

        // 3: unmapped read
        request(1'b0, 2'd2, 32'h2000_0000, 32'd0);
        tick();
        check("t3_sel",   {28'd0, bus.sl_sel},    32'h0);
        check("t3_early", {31'd0, bus.cpu_ready}, 32'd0);
        tick();
        check("t3_ready", {31'd0, bus.cpu_ready}, 32'd1);
        check("t3_err",   {31'd0, bus.cpu_err},   32'd1);
        check("t3_sel2",  {28'd0, bus.sl_sel},    32'h0);
        idle_bus();
        tick();

        // 4: region2 read (2 waits), slave never acks -> 255 ACCESS cycles
        request(1'b0, 2'd2, 32'hFFFF_0010, 32'd0);
        tick();
        tick();
        tick();
        check("t4_sel", {28'd0, bus.sl_sel}, 32'h4);
        n_ticks = 3;
        wait_ready(400, n_ticks);
        check("t4_lat",   n_ticks,                32'd258);
        check("t4_err",   {31'd0, bus.cpu_err},   32'd1);
        check("t4_sel0",  {28'd0, bus.sl_sel},    32'h0);
        idle_bus();
        tick();
        request(1'b1, 2'd2, 32'h1001_0010, 32'h5555_AAAA);
        bus.sl_ack = 4'b0001;
        n_ticks = 0;
        wait_ready(20, n_ticks);
        check("t4_next_lat", n_ticks,              32'd2);
        check("t4_next_err", {31'd0, bus.cpu_err}, 32'd0);
        idle_bus();
        tick();

        // 5: reset asserted during WAIT
        request(1'b0, 2'd2, 32'hFFFF_0024, 32'd0);
        tick();
        check("t5_addr", bus.sl_addr, 32'h24);
        reset = 1'b0;
        #1;
        check("t5_rst_addr",  bus.sl_addr,              32'd0);
        check("t5_rst_ready", {31'd0, bus.cpu_ready},   32'd0);
        check("t5_rst_sel",   {28'd0, bus.sl_sel},      32'h0);
        idle_bus();
        tick();
        tick();
        tick();
        reset = 1'b1;
        saw_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.cpu_ready === 1'b1)
                saw_ready = 1'b1;
        end
        check("t5_stale", {31'd0, saw_ready}, 32'd0);

        // 6: misaligned word read
        bus.sl_rdata[31:0] = 32'hCAFE_F00D;
        request(1'b0, 2'd2, 32'h1001_0002, 32'd0);
        bus.sl_ack = 4'b0001;
        tick();
`ifdef MISALIGN_CHECK_EN
        check("t6_sel", {28'd0, bus.sl_sel}, 32'h0);
        tick();
        check("t6_ready", {31'd0, bus.cpu_ready}, 32'd1);
        check("t6_err",   {31'd0, bus.cpu_err},   32'd1);
`else
        check("t6_sel",  {28'd0, bus.sl_sel}, 32'h1);
        check("t6_addr", bus.sl_addr,         32'h0);
        tick();
        check("t6_ready", {31'd0, bus.cpu_ready}, 32'd1);
        check("t6_err",   {31'd0, bus.cpu_err},   32'd0);
        check("t6_rdata", bus.cpu_rdata,          32'hCAFE_F00D);
`endif
        idle_bus();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
